// File: rtl/ysyx_24090012_mrom_rd_slv.sv
// ----------------------------------------------------------------------------
// ysyx_24090012_mrom_rd_slv
// AXI4 read-only slave in front of a combinational mask ROM. Accepts one read
// burst at a time, waits a fixed number of cycles, then streams the burst
// beats, walking rom_addr through FIXED / INCR / WRAP address sequences.
// Malformed requests and beats outside the ROM window return SLVERR with
// zero data, but the full beat count is always returned.
//
// Ports:
//   clock, reset          - clock; asynchronous active-high reset
//   io_slave_ar*          - read address channel (valid/ready/addr/id/len/size/burst)
//   io_slave_r*           - read data channel (valid/ready/data/id/last/resp)
//   rom_addr              - registered, word-aligned byte address of current beat
//   rom_rdata             - ROM word at rom_addr (combinational lookup)
// ----------------------------------------------------------------------------
module ysyx_24090012_mrom_rd_slv #(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int          SIZE_WORDS = 1024,
  parameter int          LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_slave_arvalid,
  output logic        io_slave_arready,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  output logic        io_slave_rvalid,
  output logic [31:0] io_slave_rdata,
  output logic [3:0]  io_slave_rid,
  output logic        io_slave_rlast,
  output logic [1:0]  io_slave_rresp,
  input  logic        io_slave_rready,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [3:0]  LAT    = 4'(LATENCY);
  // Window bounds kept 33 bits wide so a window ending at 4 GiB still compares.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(SIZE_WORDS) * 33'd4;

  logic [1:0]  state_reg, state_next;
  logic [31:0] addr_reg,  addr_next;
  logic [3:0]  id_reg,    id_next;
  logic [7:0]  len_reg,   len_next;
  logic [1:0]  burst_reg, burst_next;
  logic        err_reg,   err_next;
  logic [7:0]  beat_reg,  beat_next;
  logic [3:0]  lat_reg,   lat_next;

  logic        ar_fire, r_fire, last_beat, ar_err, wrap_len_ok;
  logic        in_range, beat_err;
  logic [31:0] wrap_mask, addr_adv;

  assign io_slave_arready = (state_reg == S_IDLE) && !reset;
  assign io_slave_rvalid  = (state_reg == S_DATA);
  assign ar_fire          = io_slave_arvalid && io_slave_arready;
  assign r_fire           = io_slave_rvalid && io_slave_rready;
  assign last_beat        = (beat_reg == len_reg);

  assign wrap_len_ok = (io_slave_arlen == 8'd1) || (io_slave_arlen == 8'd3) ||
                       (io_slave_arlen == 8'd7) || (io_slave_arlen == 8'd15);
  // Whole-transaction error is decided once at the handshake and latched.
  assign ar_err = (io_slave_arsize != 3'b010) || (io_slave_araddr[1:0] != 2'b00) ||
                  (io_slave_arburst == 2'b11) ||
                  ((io_slave_arburst == 2'b10) && !wrap_len_ok);

  // WRAP block is (len+1) words; len is 2^n-1 for legal wraps, so len,2'b11 is the offset mask.
  assign wrap_mask = {22'd0, len_reg, 2'b11};

  always_comb begin
    addr_adv = addr_reg;
    case (burst_reg)
      2'b00:   addr_adv = addr_reg;
      2'b01:   addr_adv = addr_reg + 32'd4;
      default: addr_adv = (addr_reg & ~wrap_mask) | ((addr_reg + 32'd4) & wrap_mask);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    id_next    = id_reg;
    len_next   = len_reg;
    burst_next = burst_reg;
    err_next   = err_reg;
    beat_next  = beat_reg;
    lat_next   = lat_reg;
    case (state_reg)
      S_IDLE: begin
        if (ar_fire) begin
          addr_next  = {io_slave_araddr[31:2], 2'b00};
          id_next    = io_slave_arid;
          len_next   = io_slave_arlen;
          burst_next = io_slave_arburst;
          err_next   = ar_err;
          beat_next  = 8'd0;
          lat_next   = LAT;
          // Latency 0 and 1 both present data in the cycle after the handshake.
          state_next = (LAT <= 4'd1) ? S_DATA : S_WAIT;
        end
      end
      S_WAIT: begin
        lat_next = lat_reg - 4'd1;
        if (lat_reg <= 4'd2) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (r_fire) begin
          if (last_beat) begin
            state_next = S_IDLE;
          end else begin
            beat_next = beat_reg + 8'd1;
            addr_next = addr_adv;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      addr_reg  <= 32'd0;
      id_reg    <= 4'd0;
      len_reg   <= 8'd0;
      burst_reg <= 2'd0;
      err_reg   <= 1'b0;
      beat_reg  <= 8'd0;
      lat_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      id_reg    <= id_next;
      len_reg   <= len_next;
      burst_reg <= burst_next;
      err_reg   <= err_next;
      beat_reg  <= beat_next;
      lat_reg   <= lat_next;
    end
  end

  // Outputs derive from registered state only, so they hold while stalled.
  assign rom_addr = addr_reg;
  assign in_range = ({1'b0, addr_reg} >= WIN_LO) && ({1'b0, addr_reg} < WIN_HI);
  assign beat_err = err_reg || !in_range;

  assign io_slave_rdata = (io_slave_rvalid && !beat_err) ? rom_rdata : 32'd0;
  assign io_slave_rresp = (io_slave_rvalid && beat_err) ? 2'b10 : 2'b00;
  assign io_slave_rid   = io_slave_rvalid ? id_reg : 4'd0;
  assign io_slave_rlast = io_slave_rvalid && last_beat;

endmodule

// File: tb/tb_ysyx_24090012_mrom_rd_slv.sv
module tb_ysyx_24090012_mrom_rd_slv;

  logic        clock = 1'b0;
  logic        reset;
  logic        arvalid = 1'b0;
  logic [31:0] araddr = 32'd0;
  logic [3:0]  arid = 4'd0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'b010;
  logic [1:0]  arburst = 2'b01;
  logic        rready = 1'b0;

  logic        a_arready, a_rvalid, a_rlast, b_arready, b_rvalid, b_rlast;
  logic [31:0] a_rdata, a_rom_addr, b_rdata, b_rom_addr;
  logic [3:0]  a_rid, b_rid;
  logic [1:0]  a_rresp, b_rresp;

  always #5 clock = ~clock;

  // Default-latency instance
  ysyx_24090012_mrom_rd_slv dut (
    .clock(clock), .reset(reset),
    .io_slave_arvalid(arvalid), .io_slave_arready(a_arready),
    .io_slave_araddr(araddr), .io_slave_arid(arid), .io_slave_arlen(arlen),
    .io_slave_arsize(arsize), .io_slave_arburst(arburst),
    .io_slave_rvalid(a_rvalid), .io_slave_rdata(a_rdata), .io_slave_rid(a_rid),
    .io_slave_rlast(a_rlast), .io_slave_rresp(a_rresp), .io_slave_rready(rready),
    .rom_addr(a_rom_addr), .rom_rdata(a_rom_addr)
  );

  // Zero-latency instance
  ysyx_24090012_mrom_rd_slv #(.LATENCY(0)) dut0 (
    .clock(clock), .reset(reset),
    .io_slave_arvalid(arvalid), .io_slave_arready(b_arready),
    .io_slave_araddr(araddr), .io_slave_arid(arid), .io_slave_arlen(arlen),
    .io_slave_arsize(arsize), .io_slave_arburst(arburst),
    .io_slave_rvalid(b_rvalid), .io_slave_rdata(b_rdata), .io_slave_rid(b_rid),
    .io_slave_rlast(b_rlast), .io_slave_rresp(b_rresp), .io_slave_rready(rready),
    .rom_addr(b_rom_addr), .rom_rdata(b_rom_addr)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
    logic [1:0]  resp;
  } rbeat_t;

  typedef struct packed {
    int     cyc;
    logic   acc;
    rbeat_t b;
  } trace_t;

  bit     sel0 = 1'b0;
  logic   mon_arready, mon_rvalid;
  rbeat_t mon_beat;
  assign mon_arready = sel0 ? b_arready : a_arready;
  assign mon_rvalid  = sel0 ? b_rvalid : a_rvalid;
  assign mon_beat    = sel0 ? {b_rdata, b_rid, b_rlast, b_rresp}
                            : {a_rdata, a_rid, a_rlast, a_rresp};

  rbeat_t exp_q[$];
  trace_t tr_q[$];
  int     pass_cnt = 0;
  int     total_cnt = 0;
  int     first_cyc;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] id,
                          input logic last, input logic [1:0] resp);
    rbeat_t e;
    e.data = d; e.id = id; e.last = last; e.resp = resp;
    exp_q.push_back(e);
  endtask

  // Drive one AR request and hold it until the monitored slave takes it.
  task automatic issue(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit ok = 1'b0;
    arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
    for (int i = 0; i < 20; i++) begin
      if (mon_arready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    arvalid = 1'b0;
    total_cnt++;
    if (!ok) $display("FAIL ar_handshake: arready got 0 for 20 cycles, need 1");
    else pass_cnt++;
  endtask

  // Record every rvalid cycle; rready follows pat (bit 0 first) once data shows.
  task automatic collect(input int nbeats, input logic [15:0] pat, input int patlen);
    int     acc = 0;
    int     idx = 0;
    trace_t t;
    first_cyc = -1;
    tr_q.delete();
    for (int cyc = 1; cyc <= 64 && acc < nbeats; cyc++) begin
      if (mon_rvalid) begin
        if (first_cyc < 0) first_cyc = cyc;
        rready = pat[idx % patlen];
        idx++;
        t.cyc = cyc; t.acc = rready; t.b = mon_beat;
        tr_q.push_back(t);
        if (rready) acc++;
      end else begin
        rready = 1'b0;
      end
      tick();
    end
    rready = 1'b0;
  endtask

  // Let both instances finish whatever they hold before the next scenario.
  task automatic drain();
    rready = 1'b1;
    repeat (12) tick();
    rready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if (a_arready !== 1'b0) $display("FAIL reset_arready: got %0b need 0", a_arready);
    else pass_cnt++;
    total_cnt++;
    if ({a_rvalid, a_rlast, a_rresp, a_rid, a_rdata, a_rom_addr} !== 72'd0)
      $display("FAIL reset_outputs: got rvalid=%0b rdata=%h rom_addr=%h need all 0",
               a_rvalid, a_rdata, a_rom_addr);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (a_arready !== 1'b1) $display("FAIL release_arready: got %0b need 1", a_arready);
    else pass_cnt++;
    $display("reset: arready=%0b rvalid=%0b after release", a_arready, a_rvalid);
    tick();
  endtask

  task automatic test_incr();
    rbeat_t e;
    sel0 = 1'b0;
    push_exp(32'h2000_0010, 4'd3, 1'b0, 2'b00);
    push_exp(32'h2000_0014, 4'd3, 1'b0, 2'b00);
    push_exp(32'h2000_0018, 4'd3, 1'b0, 2'b00);
    push_exp(32'h2000_001C, 4'd3, 1'b1, 2'b00);
    issue(32'h2000_0010, 4'd3, 8'd3, 3'b010, 2'b01);
    total_cnt++;
    if (a_arready !== 1'b0) $display("FAIL incr_busy_arready: got %0b need 0", a_arready);
    else pass_cnt++;
    collect(4, 16'h0001, 1);
    total_cnt++;
    if (first_cyc != 2) $display("FAIL incr_latency: got %0d need 2", first_cyc);
    else pass_cnt++;
    total_cnt++;
    if (tr_q.size() != 4) $display("FAIL incr_consecutive: got %0d valid cycles need 4", tr_q.size());
    else pass_cnt++;
    foreach (tr_q[i]) if (tr_q[i].acc) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (tr_q[i].b !== e) $display("FAIL incr_beat%0d: got %h need %h", i, tr_q[i].b, e);
      else pass_cnt++;
      $display("incr beat: rdata=%h rid=%0d rlast=%0b rresp=%0d", tr_q[i].b.data,
               tr_q[i].b.id, tr_q[i].b.last, tr_q[i].b.resp);
    end
    total_cnt++;
    if ({a_rvalid, a_arready} !== 2'b01)
      $display("FAIL incr_back_to_idle: got rvalid=%0b arready=%0b need 0/1", a_rvalid, a_arready);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    rbeat_t e;
    int     stalls = 0;
    sel0 = 1'b0;
    push_exp(32'h2000_0010, 4'd3, 1'b0, 2'b00);
    push_exp(32'h2000_0014, 4'd3, 1'b0, 2'b00);
    push_exp(32'h2000_0018, 4'd3, 1'b0, 2'b00);
    push_exp(32'h2000_001C, 4'd3, 1'b1, 2'b00);
    issue(32'h2000_0010, 4'd3, 8'd3, 3'b010, 2'b01);
    collect(4, 16'h0069, 7);
    for (int i = 1; i < tr_q.size(); i++) begin
      if (!tr_q[i-1].acc) begin
        stalls++;
        total_cnt++;
        if (tr_q[i].b !== tr_q[i-1].b)
          $display("FAIL bp_hold%0d: got %h need %h", i, tr_q[i].b, tr_q[i-1].b);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (stalls != 3) $display("FAIL bp_stall_count: got %0d need 3", stalls);
    else pass_cnt++;
    foreach (tr_q[i]) if (tr_q[i].acc) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (tr_q[i].b !== e) $display("FAIL bp_beat%0d: got %h need %h", i, tr_q[i].b, e);
      else pass_cnt++;
      $display("bp beat: cyc=%0d rdata=%h rlast=%0b", tr_q[i].cyc, tr_q[i].b.data, tr_q[i].b.last);
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL bp_beats_left: got %0d unreturned need 0", exp_q.size());
    else pass_cnt++;
    drain();
  endtask

  task automatic test_wrap();
    rbeat_t e;
    sel0 = 1'b0;
    push_exp(32'h2000_0018, 4'd5, 1'b0, 2'b00);
    push_exp(32'h2000_001C, 4'd5, 1'b0, 2'b00);
    push_exp(32'h2000_0010, 4'd5, 1'b0, 2'b00);
    push_exp(32'h2000_0014, 4'd5, 1'b1, 2'b00);
    issue(32'h2000_0018, 4'd5, 8'd3, 3'b010, 2'b10);
    collect(4, 16'h0001, 1);
    foreach (tr_q[i]) if (tr_q[i].acc) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (tr_q[i].b !== e) $display("FAIL wrap_beat%0d: got %h need %h", i, tr_q[i].b, e);
      else pass_cnt++;
      $display("wrap beat: rdata=%h rlast=%0b", tr_q[i].b.data, tr_q[i].b.last);
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL wrap_beats_left: got %0d unreturned need 0", exp_q.size());
    else pass_cnt++;
    drain();
  endtask

  task automatic test_errors();
    rbeat_t e;
    sel0 = 1'b0;
    // Burst crossing the top of the window
    push_exp(32'h2000_0FF8, 4'd1, 1'b0, 2'b00);
    push_exp(32'h2000_0FFC, 4'd1, 1'b0, 2'b00);
    push_exp(32'h0000_0000, 4'd1, 1'b0, 2'b10);
    push_exp(32'h0000_0000, 4'd1, 1'b1, 2'b10);
    issue(32'h2000_0FF8, 4'd1, 8'd3, 3'b010, 2'b01);
    collect(4, 16'h0001, 1);
    foreach (tr_q[i]) if (tr_q[i].acc) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (tr_q[i].b !== e) $display("FAIL range_beat%0d: got %h need %h", i, tr_q[i].b, e);
      else pass_cnt++;
      $display("range beat: rdata=%h rresp=%0d", tr_q[i].b.data, tr_q[i].b.resp);
    end
    drain();
    // Unsupported beat size
    push_exp(32'h0, 4'd2, 1'b0, 2'b10);
    push_exp(32'h0, 4'd2, 1'b1, 2'b10);
    issue(32'h2000_0000, 4'd2, 8'd1, 3'b011, 2'b01);
    collect(2, 16'h0001, 1);
    foreach (tr_q[i]) if (tr_q[i].acc) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (tr_q[i].b !== e) $display("FAIL size_beat%0d: got %h need %h", i, tr_q[i].b, e);
      else pass_cnt++;
      $display("size-err beat: rresp=%0d rlast=%0b", tr_q[i].b.resp, tr_q[i].b.last);
    end
    total_cnt++;
    if (a_rvalid !== 1'b0) $display("FAIL size_beat_count: got rvalid=%0b after 2 beats need 0", a_rvalid);
    else pass_cnt++;
    drain();
    // WRAP with an illegal length still returns len+1 beats
    push_exp(32'h0, 4'd6, 1'b0, 2'b10);
    push_exp(32'h0, 4'd6, 1'b0, 2'b10);
    push_exp(32'h0, 4'd6, 1'b1, 2'b10);
    issue(32'h2000_0000, 4'd6, 8'd2, 3'b010, 2'b10);
    collect(3, 16'h0001, 1);
    foreach (tr_q[i]) if (tr_q[i].acc) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (tr_q[i].b !== e) $display("FAIL wraplen_beat%0d: got %h need %h", i, tr_q[i].b, e);
      else pass_cnt++;
      $display("wraplen-err beat: rresp=%0d rlast=%0b", tr_q[i].b.resp, tr_q[i].b.last);
    end
    drain();
  endtask

  task automatic test_reset_midburst();
    rbeat_t e;
    int     stray = 0;
    sel0 = 1'b0;
    push_exp(32'h2000_0000, 4'd4, 1'b0, 2'b00);
    push_exp(32'h2000_0004, 4'd4, 1'b0, 2'b00);
    issue(32'h2000_0000, 4'd4, 8'd3, 3'b010, 2'b01);
    collect(2, 16'h0001, 1);
    foreach (tr_q[i]) if (tr_q[i].acc) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (tr_q[i].b !== e) $display("FAIL mid_beat%0d: got %h need %h", i, tr_q[i].b, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (a_rvalid !== 1'b1) $display("FAIL mid_beat3_pending: got rvalid=%0b need 1", a_rvalid);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({a_rvalid, a_rlast, a_rresp, a_rid, a_rdata, a_rom_addr, a_arready} !== 73'd0)
      $display("FAIL mid_async_clear: got rvalid=%0b rdata=%h rom_addr=%h arready=%0b need all 0",
               a_rvalid, a_rdata, a_rom_addr, a_arready);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    #1;
    total_cnt++;
    if (a_arready !== 1'b1) $display("FAIL mid_release_arready: got %0b need 1", a_arready);
    else pass_cnt++;
    rready = 1'b1;
    repeat (8) begin
      if (a_rvalid !== 1'b0) stray++;
      tick();
    end
    rready = 1'b0;
    total_cnt++;
    if (stray != 0) $display("FAIL mid_no_stray_beats: got %0d rvalid cycles need 0", stray);
    else pass_cnt++;
    $display("reset mid-burst: stray rvalid cycles=%0d", stray);
    drain();
  endtask

  task automatic test_lat0_fixed();
    rbeat_t e;
    sel0 = 1'b1;
    push_exp(32'h2000_0040, 4'd7, 1'b0, 2'b00);
    push_exp(32'h2000_0040, 4'd7, 1'b0, 2'b00);
    push_exp(32'h2000_0040, 4'd7, 1'b1, 2'b00);
    issue(32'h2000_0040, 4'd7, 8'd2, 3'b010, 2'b00);
    collect(3, 16'h0001, 1);
    total_cnt++;
    if (first_cyc != 1) $display("FAIL lat0_latency: got %0d need 1", first_cyc);
    else pass_cnt++;
    foreach (tr_q[i]) if (tr_q[i].acc) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (tr_q[i].b !== e) $display("FAIL lat0_beat%0d: got %h need %h", i, tr_q[i].b, e);
      else pass_cnt++;
      $display("lat0 fixed beat: rdata=%h rlast=%0b", tr_q[i].b.data, tr_q[i].b.last);
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL lat0_beats_left: got %0d unreturned need 0", exp_q.size());
    else pass_cnt++;
    drain();
  endtask

  initial begin
    test_reset();
    test_incr();
    test_backpressure();
    test_wrap();
    test_errors();
    test_reset_midburst();
    test_lat0_fixed();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_24090012_mrom_rd_slv.md
YSYX_24090012_MROM_RD_SLV -- requirements
Module: ysyx_24090012_mrom_rd_slv

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h2000_0000, byte address of word 0 of the ROM window.
REQ-002 SHALL have parameter SIZE_WORDS, default 1024, ROM window size in 32-bit words.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from AR handshake to first rvalid; legal range 0..15.
REQ-004 SHALL provide ports, as listed below (clock and reset first).
- clock  input  1  single clock; all state on its rising edge
- reset  input  1  asynchronous, active-high reset
- io_slave_arvalid  input  1  read address valid
- io_slave_arready  output  1  read address ready
- io_slave_araddr  input  32  burst start byte address
- io_slave_arid  input  4  transaction ID
- io_slave_arlen  input  8  beats minus 1
- io_slave_arsize  input  3  beat size; only 3'b010 supported
- io_slave_arburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- io_slave_rvalid  output  1  read data valid
- io_slave_rdata  output  32  read data
- io_slave_rid  output  4  echo of latched arid
- io_slave_rlast  output  1  final beat marker
- io_slave_rresp  output  2  00 OKAY, 10 SLVERR
- io_slave_rready  input  1  master ready
- rom_addr  output  32  current beat byte address, word aligned
- rom_rdata  input  32  combinational ROM word at rom_addr

Function
REQ-005 SHALL implement states IDLE, WAIT, DATA; one outstanding transaction only.
REQ-006 SHALL drive io_slave_arready=1 only in IDLE; AR inputs outside IDLE are ignored.
REQ-007 On arvalid&&arready SHALL latch addr, id, len, size, burst, clear beat counter, load latency counter with LATENCY, and go to WAIT (DATA directly if LATENCY=0).
REQ-008 WAIT SHALL decrement the latency counter each cycle and enter DATA on the cycle it reaches 1; rvalid SHALL be asserted exactly LATENCY cycles after the AR handshake cycle.
REQ-009 DATA SHALL drive rvalid=1, rid=latched id, rlast=(beat==len).
REQ-010 On rvalid&&rready SHALL: if rlast, go to IDLE; else increment beat and advance the address.
REQ-011 Address advance SHALL be: FIXED holds; INCR adds 4 (32-bit wrap); WRAP adds 4 within a (len+1)*4-byte aligned block, wrapping to the block base.
REQ-012 While rvalid=1 and rready=0, rdata, rid, rlast and rresp SHALL hold stable (rom_addr registered).
REQ-013 Transaction error SHALL be flagged when arsize!=3'b010, araddr[1:0]!=0, arburst=11, or WRAP with len not in {1,3,7,15}; every beat then returns rresp=10, rdata=0.
REQ-014 Per-beat range error: beat address outside [BASE_ADDR, BASE_ADDR+SIZE_WORDS*4) SHALL return rresp=10, rdata=0 for that beat only; other beats return OKAY with rdata=rom_rdata.
REQ-015 Errored transactions SHALL still return exactly len+1 beats with correct rlast.
REQ-016 When rvalid=0, rdata, rid, rlast and rresp SHALL be 0.
REQ-017 An AR handshake and the final R handshake SHALL never coincide; a new AR is accepted no earlier than the cycle after returning to IDLE.

Reset
REQ-018 Reset assertion SHALL immediately force IDLE, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, rom_addr=0, and clear all counters.
REQ-019 arready SHALL be 0 while reset is high and 1 in the first cycle after deassertion.
REQ-020 Reset mid-burst SHALL abort the burst; no remaining beats are issued after deassertion.

Verification (ROM model: rom_rdata = rom_addr)
REQ-021 arid=3, araddr=0x2000_0010, arlen=3, INCR, rready=1 -> rvalid 2 cycles after handshake; rdata 0x2000_0010/14/18/1C on consecutive cycles; rid=3; rlast on beat 4 only; rresp=00.
REQ-022 Same burst with rready toggled 1,0,0,1,0,1,1 -> each beat held until accepted; no beat skipped or duplicated.
REQ-023 araddr=0x2000_0018, arlen=3, WRAP -> rdata 0x18, 0x1C, 0x10, 0x14 (+0x2000_0000).
REQ-024 araddr=BASE+0xFF8, arlen=3, INCR -> beats 1-2 OKAY (0x2000_0FF8, 0x2000_0FFC); beats 3-4 rresp=10, rdata=0. Separately, arsize=3'b011, arlen=1 -> 2 SLVERR beats, rlast on 2nd.
REQ-025 Reset asserted after beat 2 of a 4-beat burst -> rvalid=0 asynchronously; after release arready=1 and rvalid stays 0 until a new AR.
REQ-026 LATENCY=0, FIXED, araddr=0x2000_0040, arlen=2 -> rvalid on the cycle after the handshake; 3 beats, each rdata=0x2000_0040.
